// File: rtl/fila_ctrl_if.sv
// Signal bundle between fila_ctrl, its two producers, its consumer and the fila queue.
// The slave modport is the controller's view; the master modport is the environment's view.
`timescale 1ns/1ps
interface fila_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             req_a;
  logic [WIDTH-1:0] data_a;
  logic             ack_a;
  logic             req_b;
  logic [WIDTH-1:0] data_b;
  logic             ack_b;
  logic             pop_req;
  logic             pop_valid;
  logic [WIDTH-1:0] pop_data;
  logic [WIDTH-1:0] q_data_in;
  logic             q_enqueue;
  logic             q_dequeue;
  logic [WIDTH-1:0] q_data_out;
  logic [7:0]       q_len;
  logic [7:0]       stall_cnt;

  modport slave (
    input  req_a, data_a, req_b, data_b, pop_req, q_data_out, q_len,
    output ack_a, ack_b, pop_valid, pop_data, q_data_in, q_enqueue, q_dequeue, stall_cnt
  );

  modport master (
    output req_a, data_a, req_b, data_b, pop_req, q_data_out, q_len,
    input  ack_a, ack_b, pop_valid, pop_data, q_data_in, q_enqueue, q_dequeue, stall_cnt
  );
endinterface

// File: rtl/fila_ctrl.sv
// Round-robin scheduler (A -> B -> pop) in front of the fila queue; one queue command per slot.
// Optional FILA_CTRL_STATS_EN builds a saturating counter of IDLE cycles with pushes blocked by full.
`timescale 1ns/1ps
module fila_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input logic       clk_10KHz,
  input logic       reset,
  fila_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;
  typedef enum logic [1:0] {SRC_A, SRC_B, SRC_P} src_t;

  localparam logic [7:0] DEPTH_Q = 8'(DEPTH);

  function automatic src_t rr_next(input src_t s);
    case (s)
      SRC_A:   return SRC_B;
      SRC_B:   return SRC_P;
      default: return SRC_A;
    endcase
  endfunction

  function automatic logic src_elig(input src_t s, input logic ea, input logic eb, input logic ep);
    case (s)
      SRC_A:   return ea;
      SRC_B:   return eb;
      default: return ep;
    endcase
  endfunction

  state_t           state, state_nx;
  src_t             rr_ptr, rr_ptr_nx;
  logic             is_pop, is_pop_nx;
  logic             ack_a, ack_a_nx, ack_b, ack_b_nx;
  logic             q_enq, q_enq_nx, q_deq, q_deq_nx;
  logic             pop_valid, pop_valid_nx;
  logic [WIDTH-1:0] q_data_in, q_data_in_nx;
  logic [WIDTH-1:0] pop_data, pop_data_nx;

  logic q_full, q_empty;
  logic elig_a, elig_b, elig_p;
  logic grant_vld;
  src_t grant, cand1, cand2;

  // q_len above DEPTH is treated as full as well.
  assign q_full  = (bus.q_len >= DEPTH_Q);
  assign q_empty = (bus.q_len == 8'd0);
  assign elig_a  = bus.req_a & ~q_full;
  assign elig_b  = bus.req_b & ~q_full;
  assign elig_p  = bus.pop_req & ~q_empty & ~pop_valid;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    grant_vld = 1'b0;
    grant     = rr_ptr;
    cand1     = rr_next(rr_ptr);
    cand2     = rr_next(cand1);
    if (src_elig(rr_ptr, elig_a, elig_b, elig_p)) begin
      grant_vld = 1'b1;
      grant     = rr_ptr;
    end else if (src_elig(cand1, elig_a, elig_b, elig_p)) begin
      grant_vld = 1'b1;
      grant     = cand1;
    end else if (src_elig(cand2, elig_a, elig_b, elig_p)) begin
      grant_vld = 1'b1;
      grant     = cand2;
    end
  end

  always_comb begin
    state_nx     = state;
    rr_ptr_nx    = rr_ptr;
    is_pop_nx    = is_pop;
    ack_a_nx     = 1'b0;
    ack_b_nx     = 1'b0;
    q_enq_nx     = 1'b0;
    q_deq_nx     = 1'b0;
    pop_valid_nx = 1'b0;
    q_data_in_nx = q_data_in;
    pop_data_nx  = pop_data;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          state_nx  = SETTLE;
          rr_ptr_nx = rr_next(grant);
          is_pop_nx = (grant == SRC_P);
          case (grant)
            SRC_A: begin
              q_enq_nx     = 1'b1;
              ack_a_nx     = 1'b1;
              q_data_in_nx = bus.data_a;
            end
            SRC_B: begin
              q_enq_nx     = 1'b1;
              ack_b_nx     = 1'b1;
              q_data_in_nx = bus.data_b;
            end
            default: q_deq_nx = 1'b1;
          endcase
        end
      end
      // One idle slot lets q_len absorb the last command before the next grant.
      SETTLE:  state_nx = is_pop ? CAPTURE : IDLE;
      CAPTURE: begin
        state_nx     = IDLE;
        pop_valid_nx = 1'b1;
        pop_data_nx  = bus.q_data_out;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= SRC_A;
      is_pop    <= 1'b0;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      q_enq     <= 1'b0;
      q_deq     <= 1'b0;
      pop_valid <= 1'b0;
      q_data_in <= '0;
      pop_data  <= '0;
    end else begin
      state     <= state_nx;
      rr_ptr    <= rr_ptr_nx;
      is_pop    <= is_pop_nx;
      ack_a     <= ack_a_nx;
      ack_b     <= ack_b_nx;
      q_enq     <= q_enq_nx;
      q_deq     <= q_deq_nx;
      pop_valid <= pop_valid_nx;
      q_data_in <= q_data_in_nx;
      pop_data  <= pop_data_nx;
    end
  end

  assign bus.ack_a     = ack_a;
  assign bus.ack_b     = ack_b;
  assign bus.q_enqueue = q_enq;
  assign bus.q_dequeue = q_deq;
  assign bus.pop_valid = pop_valid;
  assign bus.q_data_in = q_data_in;
  assign bus.pop_data  = pop_data;

`ifdef FILA_CTRL_STATS_EN
  logic [7:0] stall_cnt;

  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      stall_cnt <= 8'd0;
    end else if ((state == IDLE) && (bus.req_a | bus.req_b) && q_full && (stall_cnt != 8'hFF)) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt;
`else
  assign bus.stall_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_fila_ctrl.sv
// Directed bench for fila_ctrl: reset, single push, round-robin order, full/empty, pop latency, reset abort.
// The queue side is driven directly by the bench (q_len, q_data_out) as directed stimulus.
`timescale 1ns/1ps
module tb_fila_ctrl;
  logic clk_10KHz = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   deq_count;

  fila_ctrl_if #(.WIDTH(8)) ifc ();

  fila_ctrl #(.WIDTH(8), .DEPTH(8)) dut (
    .clk_10KHz (clk_10KHz),
    .reset     (reset),
    .bus       (ifc)
  );

  always #5 clk_10KHz = ~clk_10KHz;

`ifdef FILA_CTRL_STATS_EN
  localparam logic [7:0] STALL_EXP = 8'd4;
`else
  localparam logic [7:0] STALL_EXP = 8'd0;
`endif

  // Flag order: {ack_a, ack_b, q_enqueue, q_dequeue, pop_valid}
  logic [4:0] rr_exp [12] = '{5'b10100, 5'b00000, 5'b01100, 5'b00000, 5'b00010, 5'b00000,
                              5'b00001, 5'b10100, 5'b00000, 5'b01100, 5'b00000, 5'b00010};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_10KHz);
    #1;
  endtask

  function automatic logic [4:0] flags();
    return {ifc.ack_a, ifc.ack_b, ifc.q_enqueue, ifc.q_dequeue, ifc.pop_valid};
  endfunction

  initial begin
    reset          = 1'b1;
    ifc.req_a      = 1'b0;
    ifc.data_a     = 8'h00;
    ifc.req_b      = 1'b0;
    ifc.data_b     = 8'h00;
    ifc.pop_req    = 1'b0;
    ifc.q_data_out = 8'h00;
    ifc.q_len      = 8'd0;

    // Reset state
    tick();
    tick();
    check("rst_flags", 32'(flags()), 32'h0);
    check("rst_q_data_in", 32'(ifc.q_data_in), 32'h0);
    check("rst_pop_data", 32'(ifc.pop_data), 32'h0);
    check("rst_stall", 32'(ifc.stall_cnt), 32'h0);
    reset = 1'b0;

    // Single push from A, empty queue
    ifc.req_a  = 1'b1;
    ifc.data_a = 8'h11;
    tick();
    check("push_a_flags", 32'(flags()), 32'b10100);
    check("push_a_data", 32'(ifc.q_data_in), 32'h11);
    ifc.req_a = 1'b0;
    tick();
    check("push_a_settle", 32'(flags()), 32'h0);
    tick();
    check("push_a_idle", 32'(flags()), 32'h0);

    // Pointer now at B; both request, B wins, then reset aborts the command
    ifc.req_a  = 1'b1;
    ifc.data_a = 8'hA1;
    ifc.req_b  = 1'b1;
    ifc.data_b = 8'hB2;
    ifc.q_len  = 8'd3;
    tick();
    check("ptr_b_grant", 32'(flags()), 32'b01100);
    reset = 1'b1;
    #1;
    check("async_rst_flags", 32'(flags()), 32'h0);
    check("async_rst_data", 32'(ifc.q_data_in), 32'h0);
    tick();
    check("held_rst_flags", 32'(flags()), 32'h0);

    // Round-robin with all three sources active, pointer restarted at A
    ifc.pop_req    = 1'b1;
    ifc.q_data_out = 8'h77;
    reset          = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("rr_cyc%0d", i + 1), 32'(flags()), 32'(rr_exp[i]));
      if (rr_exp[i][4]) check($sformatf("rr_data_a%0d", i + 1), 32'(ifc.q_data_in), 32'hA1);
      if (rr_exp[i][3]) check($sformatf("rr_data_b%0d", i + 1), 32'(ifc.q_data_in), 32'hB2);
      if (rr_exp[i][0]) check($sformatf("rr_pop_data%0d", i + 1), 32'(ifc.pop_data), 32'h77);
    end
    ifc.req_a   = 1'b0;
    ifc.req_b   = 1'b0;
    ifc.pop_req = 1'b0;
    tick();
    check("rr_drain_capture", 32'(flags()), 32'h0);
    tick();
    check("rr_drain_valid", 32'(flags()), 32'b00001);
    tick();
    check("rr_drain_idle", 32'(flags()), 32'h0);

    // Full queue: A blocked, pop still serviced, A granted once q_len drops to 7
    ifc.q_len      = 8'd8;
    ifc.req_a      = 1'b1;
    ifc.data_a     = 8'h44;
    ifc.q_data_out = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("full_blocked%0d", i), 32'(flags()), 32'h0);
    end
    ifc.pop_req = 1'b1;
    tick();
    check("full_pop_deq", 32'(flags()), 32'b00010);
    tick();
    check("full_pop_settle", 32'(flags()), 32'h0);
    ifc.q_len = 8'd7;
    tick();
    check("full_pop_valid", 32'(flags()), 32'b00001);
    check("full_pop_data", 32'(ifc.pop_data), 32'h3C);
    ifc.pop_req = 1'b0;
    tick();
    check("after_full_push", 32'(flags()), 32'b10100);
    check("after_full_data", 32'(ifc.q_data_in), 32'h44);
    check("stall_cnt", 32'(ifc.stall_cnt), 32'(STALL_EXP));
    ifc.req_a = 1'b0;
    tick();

    // Pop latency, head 8'h5A; pop_req held one cycle past valid to exercise the mask
    ifc.q_len      = 8'd1;
    ifc.q_data_out = 8'h5A;
    ifc.pop_req    = 1'b1;
    deq_count      = 0;
    tick();
    deq_count += int'(ifc.q_dequeue);
    check("pop_e0_deq", 32'(flags()), 32'b00010);
    tick();
    deq_count += int'(ifc.q_dequeue);
    check("pop_e1", 32'(flags()), 32'h0);
    tick();
    deq_count += int'(ifc.q_dequeue);
    check("pop_e2_valid", 32'(flags()), 32'b00001);
    check("pop_e2_data", 32'(ifc.pop_data), 32'h5A);
    tick();
    deq_count += int'(ifc.q_dequeue);
    check("pop_masked", 32'(flags()), 32'h0);
    ifc.pop_req = 1'b0;
    check("pop_deq_count", 32'(deq_count), 32'd1);

    // Reset while in CAPTURE: no pop_valid, pop_data cleared, request re-arbitrates
    ifc.q_data_out = 8'hC3;
    ifc.pop_req    = 1'b1;
    tick();
    check("cap_rst_deq", 32'(flags()), 32'b00010);
    tick();
    check("cap_rst_settle", 32'(flags()), 32'h0);
    reset = 1'b1;
    #1;
    check("cap_rst_flags", 32'(flags()), 32'h0);
    check("cap_rst_pop_data", 32'(ifc.pop_data), 32'h0);
    tick();
    check("cap_rst_no_valid", 32'(flags()), 32'h0);
    reset = 1'b0;
    tick();
    check("rearb_deq", 32'(flags()), 32'b00010);
    ifc.pop_req = 1'b0;
    tick();
    check("rearb_settle", 32'(flags()), 32'h0);
    tick();
    check("rearb_valid", 32'(flags()), 32'b00001);
    check("rearb_data", 32'(ifc.pop_data), 32'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
